// File: rtl/mod_pkg.sv
// Shared definitions for the repeated-subtraction modulo control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mod_pkg;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_MAX_ITER = 256;

   // Fixed encoding so state can be matched against waveforms and other tools.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/mod_quot_cnt.sv
// Quotient counter: clears on an accepted start, increments once per subtraction, flags the limit.
// Latency: count updates on the edge after clr/inc; at_lim is combinational on the registered count.
// Backpressure: none; clr has priority over inc.
module mod_quot_cnt
   import mod_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int LIMIT    = DEF_MAX_ITER,
   parameter bit LIMIT_EN = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt,
   output logic             at_lim
);

   // Compare in at least 32 bits so a limit wider than the counter never aliases to a small value.
   localparam int            CW  = (WIDTH > 32) ? WIDTH : 32;
   localparam logic [CW-1:0] LIM = CW'(LIMIT);

   logic [CW-1:0] cnt_ext;

   assign cnt_ext = CW'(cnt);
   assign at_lim  = LIMIT_EN && (cnt_ext == LIM);

   // Counter register: clear wins over increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mod_ctrl.sv
// Control FSM for the modulo datapath: one A mod B per start, quotient count, divide-by-zero flag.
// Latency: ld_temp in cycle T1 after start, q subtract cycles, done in cycle T3+q (T1 when B==0).
// Backpressure: start ignored while busy, no queueing; optional iteration limit under MOD_ITER_LIMIT_EN.
module mod_ctrl
   import mod_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAX_ITER = DEF_MAX_ITER
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] B,
   input  logic             comp,
   output logic             ld_temp,
   output logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic             err_div0,
   output logic             timeout
);

`ifdef MOD_ITER_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   state_t state;
   logic   b_zero;
   logic   accept;
   logic   at_lim;

   assign b_zero = (B == '0);
   assign accept = (state == S_IDLE) && start && !b_zero;

   // sub is the only output that looks at comp; at the limit it is held off so TEMP keeps the partial remainder.
   assign sub = (state == S_RUN) && comp && !at_lim;

   mod_quot_cnt #(
      .WIDTH    (WIDTH),
      .LIMIT    (MAX_ITER),
      .LIMIT_EN (LIMIT_EN)
   ) u_quot_cnt (
      .clk    (clk),
      .reset  (reset),
      .clr    (accept),
      .inc    (sub),
      .cnt    (quot),
      .at_lim (at_lim)
   );

`ifdef MOD_ITER_LIMIT_EN
   logic timeout_q;
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   // State machine with registered ld_temp/busy/done and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         ld_temp  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err_div0 <= 1'b0;
`ifdef MOD_ITER_LIMIT_EN
         timeout_q <= 1'b0;
`endif
      end else begin
         ld_temp <= 1'b0;
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (b_zero) begin
                     // Skip the datapath entirely; report the error straight away.
                     err_div0 <= 1'b1;
                     done     <= 1'b1;
                     state    <= S_FIN;
                  end else begin
                     err_div0 <= 1'b0;
`ifdef MOD_ITER_LIMIT_EN
                     timeout_q <= 1'b0;
`endif
                     ld_temp  <= 1'b1;
                     state    <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               state <= S_RUN;
            end
            S_RUN: begin
               if (comp && at_lim) begin
`ifdef MOD_ITER_LIMIT_EN
                  timeout_q <= 1'b1;
`endif
                  done  <= 1'b1;
                  state <= S_FIN;
               end else if (!comp) begin
                  done  <= 1'b1;
                  state <= S_FIN;
               end
            end
            S_FIN: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod_ctrl.sv
// Directed bench for mod_ctrl with a behavioural TEMP register standing in for the datapath.
// Latency: checks done timing cycle by cycle from the start edge.
// Backpressure: checks that a start while busy is ignored and that mid-run reset aborts cleanly.
module tb_mod_ctrl;

   localparam int WIDTH = 8;
`ifdef MOD_ITER_LIMIT_EN
   localparam int MAX_ITER = 4;
`else
   localparam int MAX_ITER = 256;
`endif

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      int q;
      int temp;
      int div0;
      int to;
      int lat;
      int subs;
      int lds;
      int poke;
   } vec_t;

   logic             clk   = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] A     = '0;
   logic [WIDTH-1:0] B     = '0;
   logic [WIDTH-1:0] temp;
   logic             comp;
   logic             ld_temp;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quot;
   logic             err_div0;
   logic             timeout;

   int checks = 0;
   int errors = 0;

   vec_t tbl[8];
   int   nrows;

   always #5 clk = ~clk;

   mod_ctrl #(
      .WIDTH    (WIDTH),
      .MAX_ITER (MAX_ITER)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .B        (B),
      .comp     (comp),
      .ld_temp  (ld_temp),
      .sub      (sub),
      .busy     (busy),
      .done     (done),
      .quot     (quot),
      .err_div0 (err_div0),
      .timeout  (timeout)
   );

   // Behavioural datapath: TEMP loads A or subtracts B on command.
   always @(posedge clk or negedge reset) begin
      if (!reset)       temp <= '0;
      else if (ld_temp) temp <= A;
      else if (sub)     temp <= temp - B;
   end
   assign comp = (temp >= B);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One operation: pulse start, follow it cycle by cycle until done, then compare results.
   task automatic run_op(input vec_t v);
      int n, lat, subs, lds, bad;
      logic [31:0] q_s, t_s, e_s, to_s;
      A = v.a;
      B = v.b;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 1; lat = 0; subs = 0; lds = 0; bad = 0;
      q_s = '0; t_s = '0; e_s = '0; to_s = '0;
      while (lat == 0 && n < 600) begin
         if (ld_temp) lds++;
         if (sub) subs++;
         if (ld_temp && sub) bad++;
         if (sub && !busy) bad++;
         if (!busy) bad++;
         if (done) begin
            lat  = n;
            q_s  = 32'(quot);
            t_s  = 32'(temp);
            e_s  = 32'(err_div0);
            to_s = 32'(timeout);
         end else begin
            start = (v.poke != 0 && n == v.poke);
            @(posedge clk);
            #1;
            n++;
         end
      end
      start = 1'b0;
      chk("done_latency", lat, v.lat);
      chk("quot", q_s, v.q);
      chk("temp", t_s, v.temp);
      chk("err_div0", e_s, v.div0);
      chk("timeout", to_s, v.to);
      chk("sub_cycles", subs, v.subs);
      chk("ld_temp_cycles", lds, v.lds);
      chk("protocol_violations", bad, 0);
      @(posedge clk);
      #1;
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      chk("quot_held", quot, v.q);
   endtask

   initial begin
      // A, B, q, TEMP, div0, timeout, done cycle, subs, ld pulses, start poke cycle
      tbl[0] = '{8'd17,  8'd5,   3,   2,  0, 0,   6,   3, 1, 0};
      tbl[1] = '{8'd3,   8'd7,   0,   3,  0, 0,   3,   0, 1, 0};
      tbl[2] = '{8'd9,   8'd0,   0,   3,  1, 0,   1,   0, 0, 0};
      tbl[3] = '{8'd9,   8'd3,   3,   0,  0, 0,   6,   3, 1, 0};
`ifdef MOD_ITER_LIMIT_EN
      tbl[4] = '{8'd100, 8'd3,   4,   88, 0, 1,   7,   4, 1, 0};
      nrows  = 5;
`else
      tbl[4] = '{8'd255, 8'd1,   255, 0,  0, 0,   258, 255, 1, 10};
      tbl[5] = '{8'd200, 8'd7,   28,  4,  0, 0,   31,  28, 1, 0};
      tbl[6] = '{8'd255, 8'd255, 1,   0,  0, 0,   4,   1, 1, 0};
      nrows  = 7;
`endif

      // Reset values while reset is held low.
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ld_temp", ld_temp, 0);
      chk("rst_sub", sub, 0);
      chk("rst_quot", quot, 0);
      chk("rst_err_div0", err_div0, 0);
      chk("rst_timeout", timeout, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < nrows; i++) begin
         run_op(tbl[i]);
      end

`ifndef MOD_ITER_LIMIT_EN
      // Reset in the middle of a run: abort immediately, then a clean rerun.
      begin
         int subs, dn;
         vec_t v;
         A = 8'd100;
         B = 8'd3;
         subs = 0;
         @(negedge clk);
         start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         for (int i = 0; i < 50 && subs < 5; i++) begin
            if (sub) subs++;
            @(posedge clk);
            #1;
         end
         chk("mid_reset_subs_seen", subs, 5);
         reset = 1'b0;
         #1;
         chk("mid_reset_busy", busy, 0);
         chk("mid_reset_quot", quot, 0);
         chk("mid_reset_done", done, 0);
         chk("mid_reset_sub", sub, 0);
         dn = 0;
         repeat (3) begin
            @(posedge clk);
            #1;
            if (done || busy) dn++;
         end
         chk("mid_reset_quiet", dn, 0);
         @(negedge clk);
         reset = 1'b1;
         @(posedge clk);
         v = '{8'd100, 8'd3, 33, 1, 0, 0, 36, 33, 1, 0};
         run_op(v);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
